// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that shares one single-port data memory
// between the core load/store stage (port 0) and a loader/debug master (port 1).
// Misaligned accesses are granted but never reach the memory. They are answered
// with an error response instead.
module dmem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_is_load,
    input  logic              p0_is_store,
    input  logic [5:0]        p0_alucode,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic              p1_req,
    input  logic              p1_is_load,
    input  logic              p1_is_store,
    input  logic [5:0]        p1_alucode,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic              p0_err,
    output logic              p1_err,
    output logic [31:0]       p0_rdata,
    output logic [31:0]       p1_rdata,
    output logic              mem_is_load,
    output logic              mem_is_store,
    output logic [5:0]        mem_alucode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // Access codes shared with the data memory.
    localparam logic [5:0] ALU_LB  = 6'd18;
    localparam logic [5:0] ALU_LH  = 6'd19;
    localparam logic [5:0] ALU_LW  = 6'd20;
    localparam logic [5:0] ALU_LBU = 6'd21;
    localparam logic [5:0] ALU_LHU = 6'd22;
    localparam logic [5:0] ALU_SB  = 6'd23;
    localparam logic [5:0] ALU_SH  = 6'd24;
    localparam logic [5:0] ALU_SW  = 6'd25;

    // Halfwords may sit at offset 0..2 of a word. Only offset 3 would straddle
    // two words. Words must be word aligned. Byte accesses are always legal.
    function automatic logic is_misaligned(input logic [5:0] code, input logic [1:0] lo);
        logic bad;
        case (code)
            ALU_LH, ALU_LHU, ALU_SH: bad = (lo == 2'd3);
            ALU_LW, ALU_SW:          bad = (lo != 2'd0);
            ALU_LB, ALU_LBU, ALU_SB: bad = 1'b0;
            default:                 bad = 1'b0;
        endcase
        return bad;
    endfunction

    logic        prio_r;        // port favoured when both request
    logic        resp_v_r;      // a response is due this cycle
    logic        resp_owner_r;  // last granted port (owner of the pending response)
    logic        resp_load_r;
    logic        resp_err_r;

    logic        gnt0_s;
    logic        gnt1_s;
    logic        any_gnt_s;
    logic        sel_is_load_s;
    logic        sel_is_store_s;
    logic [5:0]  sel_code_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic        misalign_s;

    // Grant decision: a sole requester wins, and prio breaks a tie. Nothing is granted during reset.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (p0_req && p1_req) begin
            gnt0_s = ~prio_r;
            gnt1_s = prio_r;
        end else begin
            gnt0_s = p0_req;
            gnt1_s = p1_req;
        end
    end

    // Winner mux. With no grant the port-0 fields pass through, and the enables stay low.
    always_comb begin
        any_gnt_s = gnt0_s | gnt1_s;
        if (gnt1_s) begin
            sel_is_load_s  = p1_is_load;
            sel_is_store_s = p1_is_store;
            sel_code_s     = p1_alucode;
            sel_addr_s     = p1_addr;
            sel_wdata_s    = p1_wdata;
        end else begin
            sel_is_load_s  = p0_is_load;
            sel_is_store_s = p0_is_store;
            sel_code_s     = p0_alucode;
            sel_addr_s     = p0_addr;
            sel_wdata_s    = p0_wdata;
        end
        misalign_s = is_misaligned(sel_code_s, sel_addr_s[1:0]);
    end

    // Memory drive. Enables are qualified so that a rejected access or a reset never touches memory.
    always_comb begin
        mem_alucode  = sel_code_s;
        mem_addr     = sel_addr_s;
        mem_wdata    = sel_wdata_s;
        mem_is_load  = any_gnt_s & sel_is_load_s  & ~misalign_s & ~rst;
        mem_is_store = any_gnt_s & sel_is_store_s & ~misalign_s & ~rst;
        p0_gnt       = gnt0_s;
        p1_gnt       = gnt1_s;
    end

    // Priority flips only on a contested grant, and response tracking follows every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_r       <= 1'b0;
            resp_v_r     <= 1'b0;
            resp_owner_r <= 1'b0;
            resp_load_r  <= 1'b0;
            resp_err_r   <= 1'b0;
        end else begin
            if (p0_req && p1_req) begin
                prio_r <= ~prio_r;
            end else begin
                prio_r <= prio_r;
            end
            resp_v_r     <= any_gnt_s;
            resp_owner_r <= gnt1_s;
            resp_load_r  <= sel_is_load_s;
            resp_err_r   <= misalign_s;
        end
    end

    // Route the one-cycle-late response to its owner. The other port sees all zeros.
    always_comb begin
        logic own0_s;
        logic own1_s;
        logic [31:0] data_s;
        own0_s = resp_v_r & ~resp_owner_r;
        own1_s = resp_v_r &  resp_owner_r;
        if (resp_load_r && !resp_err_r) begin
            data_s = mem_rdata;
        end else begin
            data_s = 32'd0;
        end
        p0_rvalid = own0_s;
        p1_rvalid = own1_s;
        p0_err    = own0_s & resp_err_r;
        p1_err    = own1_s & resp_err_r;
        p0_rdata  = own0_s ? data_s : 32'd0;
        p1_rdata  = own1_s ? data_s : 32'd0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table-driven bench for dmem_arbiter with a small
// byte-addressed data memory model attached to the memory side.
module tb_dmem_arbiter;

    localparam logic [5:0] LB  = 6'd18;
    localparam logic [5:0] LH  = 6'd19;
    localparam logic [5:0] LW  = 6'd20;
    localparam logic [5:0] LBU = 6'd21;
    localparam logic [5:0] LHU = 6'd22;
    localparam logic [5:0] SB  = 6'd23;
    localparam logic [5:0] SH  = 6'd24;
    localparam logic [5:0] SW  = 6'd25;

    typedef struct {
        logic        req;
        logic        ld;
        logic        st;
        logic [5:0]  code;
        logic [31:0] addr;
        logic [31:0] wd;
    } port_t;

    typedef struct {
        logic        g0, g1, ml, ms;
        logic [31:0] ma;
        logic        v0, e0;
        logic [31:0] d0;
        logic        v1, e1;
        logic [31:0] d1;
    } exp_t;

    typedef struct {
        port_t a;
        port_t b;
        exp_t  e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req, p0_is_load, p0_is_store, p1_req, p1_is_load, p1_is_store;
    logic [5:0]  p0_alucode, p1_alucode, mem_alucode;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
    logic        mem_is_load, mem_is_store;
    logic [31:0] mem_rdata = 32'd0;

    logic [7:0]  mem [0:255];

    int checks   = 0;
    int failures = 0;
    int rowi     = -1;
    vec_t vq[$];

    dmem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_is_load(p0_is_load), .p0_is_store(p0_is_store),
        .p0_alucode(p0_alucode), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_is_load(p1_is_load), .p1_is_store(p1_is_store),
        .p1_alucode(p1_alucode), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_err(p0_err), .p1_err(p1_err),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
        .mem_alucode(mem_alucode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory model: little-endian bytes, registered read data.
    always @(posedge clk) begin
        logic [7:0] a;
        a = mem_addr[7:0];
        if (mem_is_store) begin
            case (mem_alucode)
                SB: mem[a] <= mem_wdata[7:0];
                SH: begin mem[a] <= mem_wdata[7:0]; mem[a+8'd1] <= mem_wdata[15:8]; end
                SW: begin
                    mem[a] <= mem_wdata[7:0];        mem[a+8'd1] <= mem_wdata[15:8];
                    mem[a+8'd2] <= mem_wdata[23:16]; mem[a+8'd3] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
        if (mem_is_load) begin
            case (mem_alucode)
                LB:  mem_rdata <= {{24{mem[a][7]}}, mem[a]};
                LBU: mem_rdata <= {24'd0, mem[a]};
                LH:  mem_rdata <= {{16{mem[a+8'd1][7]}}, mem[a+8'd1], mem[a]};
                LHU: mem_rdata <= {16'd0, mem[a+8'd1], mem[a]};
                LW:  mem_rdata <= {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
                default: mem_rdata <= 32'd0;
            endcase
        end
    end

    function automatic port_t pl(input logic [5:0] c, input logic [31:0] a);
        return '{req: 1'b1, ld: 1'b1, st: 1'b0, code: c, addr: a, wd: 32'd0};
    endfunction

    function automatic port_t ps(input logic [5:0] c, input logic [31:0] a, input logic [31:0] w);
        return '{req: 1'b1, ld: 1'b0, st: 1'b1, code: c, addr: a, wd: w};
    endfunction

    function automatic port_t pi();
        return '{req: 1'b0, ld: 1'b0, st: 1'b0, code: 6'd0, addr: 32'd0, wd: 32'd0};
    endfunction

    function automatic exp_t ex(input logic g0, input logic g1, input logic ml, input logic ms,
                                input logic [31:0] ma,
                                input logic v0, input logic e0, input logic [31:0] d0,
                                input logic v1, input logic e1, input logic [31:0] d1);
        return '{g0: g0, g1: g1, ml: ml, ms: ms, ma: ma,
                 v0: v0, e0: e0, d0: d0, v1: v1, e1: e1, d1: d1};
    endfunction

    task automatic add(input port_t a, input port_t b, input exp_t e);
        vq.push_back('{a: a, b: b, e: e});
    endtask

    task automatic apply(input port_t a, input port_t b);
        p0_req = a.req; p0_is_load = a.ld; p0_is_store = a.st;
        p0_alucode = a.code; p0_addr = a.addr; p0_wdata = a.wd;
        p1_req = b.req; p1_is_load = b.ld; p1_is_store = b.st;
        p1_alucode = b.code; p1_addr = b.addr; p1_wdata = b.wd;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, rowi, act, req);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("p0_gnt", {31'd0, p0_gnt}, {31'd0, e.g0});
        chk("p1_gnt", {31'd0, p1_gnt}, {31'd0, e.g1});
        chk("mem_is_load", {31'd0, mem_is_load}, {31'd0, e.ml});
        chk("mem_is_store", {31'd0, mem_is_store}, {31'd0, e.ms});
        chk("mem_addr", mem_addr, e.ma);
        chk("p0_rvalid", {31'd0, p0_rvalid}, {31'd0, e.v0});
        chk("p0_err", {31'd0, p0_err}, {31'd0, e.e0});
        chk("p0_rdata", p0_rdata, e.d0);
        chk("p1_rvalid", {31'd0, p1_rvalid}, {31'd0, e.v1});
        chk("p1_err", {31'd0, p1_err}, {31'd0, e.e1});
        chk("p1_rdata", p1_rdata, e.d1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'hDEADBEEF;
        {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} = 32'h12345678;
        {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]} = 32'hCAFEF00D;

        // single load, then idle for its response
        add(pl(LW, 32'h10), pi(), ex(1,0,1,0,32'h10, 0,0,32'h0, 0,0,32'h0));
        add(pi(), pi(),           ex(0,0,0,0,32'h0,  1,0,32'hDEADBEEF, 0,0,32'h0));
        // six cycles of contention: 0,1,0,1,0,1
        add(pl(LW, 32'h10), pl(LW, 32'h20), ex(1,0,1,0,32'h10, 0,0,32'h0, 0,0,32'h0));
        add(pl(LW, 32'h10), pl(LW, 32'h20), ex(0,1,1,0,32'h20, 1,0,32'hDEADBEEF, 0,0,32'h0));
        add(pl(LW, 32'h10), pl(LW, 32'h20), ex(1,0,1,0,32'h10, 0,0,32'h0, 1,0,32'h12345678));
        add(pl(LW, 32'h10), pl(LW, 32'h20), ex(0,1,1,0,32'h20, 1,0,32'hDEADBEEF, 0,0,32'h0));
        add(pl(LW, 32'h10), pl(LW, 32'h20), ex(1,0,1,0,32'h10, 0,0,32'h0, 1,0,32'h12345678));
        add(pl(LW, 32'h10), pl(LW, 32'h20), ex(0,1,1,0,32'h20, 1,0,32'hDEADBEEF, 0,0,32'h0));
        // misaligned SH 0x23 and LW 0x22 on port 1
        add(pi(), ps(SH, 32'h23, 32'h0000BEEF), ex(0,1,0,0,32'h23, 0,0,32'h0, 1,0,32'h12345678));
        add(pi(), pl(LW, 32'h22),               ex(0,1,0,0,32'h22, 0,0,32'h0, 1,1,32'h0));
        // store byte then load it back on the other port
        add(pi(), ps(SB, 32'h41, 32'h000000A5), ex(0,1,0,1,32'h41, 0,0,32'h0, 1,1,32'h0));
        add(pl(LBU, 32'h41), pi(),              ex(1,0,1,0,32'h41, 0,0,32'h0, 1,0,32'h0));
        add(pi(), ps(SH, 32'h42, 32'h0000BEEF), ex(0,1,0,1,32'h42, 1,0,32'h000000A5, 0,0,32'h0));
        add(pl(LHU, 32'h42), pi(),              ex(1,0,1,0,32'h42, 0,0,32'h0, 1,0,32'h0));
        // halfword at offset 1 is legal; sign extension on LH and LB
        add(pi(), pl(LH, 32'h31),  ex(0,1,1,0,32'h31, 1,0,32'h0000BEEF, 0,0,32'h0));
        add(pl(LB, 32'h33), pi(),  ex(1,0,1,0,32'h33, 0,0,32'h0, 1,0,32'hFFFFFEF0));
        add(pi(), pi(),            ex(0,0,0,0,32'h0,  1,0,32'hFFFFFFCA, 0,0,32'h0));
        // three solo port-1 grants leave prio at 0
        add(pi(), pl(LW, 32'h20), ex(0,1,1,0,32'h20, 0,0,32'h0, 0,0,32'h0));
        add(pi(), pl(LW, 32'h20), ex(0,1,1,0,32'h20, 0,0,32'h0, 1,0,32'h12345678));
        add(pi(), pl(LW, 32'h20), ex(0,1,1,0,32'h20, 0,0,32'h0, 1,0,32'h12345678));
        add(pl(LW, 32'h10), pl(LW, 32'h20), ex(1,0,1,0,32'h10, 0,0,32'h0, 1,0,32'h12345678));
        add(pl(LW, 32'h10), pl(LW, 32'h20), ex(0,1,1,0,32'h20, 1,0,32'hDEADBEEF, 0,0,32'h0));
        add(pl(LW, 32'h10), pl(LW, 32'h20), ex(1,0,1,0,32'h10, 0,0,32'h0, 1,0,32'h12345678));

        // reset state with both ports requesting
        apply(pl(LW, 32'h10), pl(LW, 32'h20));
        #2;
        chk_all(ex(0,0,0,0,32'h10, 0,0,32'h0, 0,0,32'h0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            rowi = i;
            apply(vq[i].a, vq[i].b);
            #4;
            chk_all(vq[i].e);
            @(posedge clk);
            #1;
        end

        // reset mid-access: prio is 1 here and the last row's response is pending
        rowi = 100;
        apply(pl(LW, 32'h10), pi());
        #3;
        chk_all(ex(1,0,1,0,32'h10, 1,0,32'hDEADBEEF, 0,0,32'h0));
        rst = 1'b1;
        #1;
        rowi = 101;
        chk_all(ex(0,0,0,0,32'h10, 0,0,32'h0, 0,0,32'h0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(pi(), pi());
        #3;
        rowi = 102;
        chk_all(ex(0,0,0,0,32'h0, 0,0,32'h0, 0,0,32'h0));
        @(posedge clk);
        #1;
        apply(pl(LW, 32'h10), pl(LW, 32'h20));
        #3;
        rowi = 103;
        chk_all(ex(1,0,1,0,32'h10, 0,0,32'h0, 0,0,32'h0));
        @(posedge clk);
        #1;
        #3;
        rowi = 104;
        chk_all(ex(0,1,1,0,32'h20, 1,0,32'hDEADBEEF, 0,0,32'h0));
        @(posedge clk);
        #1;
        apply(pi(), pi());
        #3;
        rowi = 105;
        chk_all(ex(0,0,0,0,32'h0, 0,0,32'h0, 1,0,32'h12345678));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the core load/store stage (port 0) and a loader/debug master (port 1). Each cycle it grants at most one request using round-robin priority. It drives the memory's `is_load`/`is_store`/`alucode`/`addr`/`w_data` inputs and routes the one-cycle-latency `r_data` back to the owning port. Misaligned accesses are rejected before they reach memory, so the memory never sees an access it cannot perform.

## Interface
- `ADDR_W`, default 32: address width of ports and memory side.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `p0_req`, `p1_req`  in  1 each  request valid; held until granted.
- `p0_is_load`/`p0_is_store`, `p1_is_load`/`p1_is_store`  in  1 each  access kind; exactly one is high when req is high.
- `p0_alucode`, `p1_alucode`  in  6 each  one of `ALU_LB/LH/LW/LBU/LHU/SB/SH/SW` from define.vh.
- `p0_addr`, `p1_addr`  in  ADDR_W each  byte address.
- `p0_wdata`, `p1_wdata`  in  32 each  store data (low bytes used for SB/SH).
- `p0_gnt`, `p1_gnt`  out  1 each  request accepted this cycle (combinational).
- `p0_rvalid`, `p1_rvalid`  out  1 each  response valid, one cycle after grant.
- `p0_err`, `p1_err`  out  1 each  qualifies rvalid: the access was rejected as misaligned.
- `p0_rdata`, `p1_rdata`  out  32 each  load data; 0 for stores and errors.
- `mem_is_load`, `mem_is_store`  out  1 each  to data memory.
- `mem_alucode`  out  6  to data memory.
- `mem_addr`  out  ADDR_W  to data memory.
- `mem_wdata`  out  32  to data memory.
- `mem_rdata`  in  32  registered read data; valid the cycle after `mem_is_load`.

## Operation
**Arbitration**
- State is `prio` (1 bit, the port favoured on conflict) and `last_owner`.
- One port requesting: that port is granted.
- Both ports requesting: `prio` is granted, and `prio` flips to the other port on the next edge.
- `prio` updates only on contested grants. A single uncontested grant leaves it unchanged.

**Misalignment check**
- Rejected when `LH`/`LHU`/`SH` has `addr[1:0]==3`.
- Rejected when `LW`/`SW` has `addr[1:0]!=0`.
- A rejected request is still granted, so the requester is not stalled.
- For a rejected request, `mem_is_load` and `mem_is_store` stay 0.

**Memory drive**
- On a grant, `mem_alucode`/`mem_addr`/`mem_wdata` are muxed from the winner.
- `mem_is_load`/`mem_is_store` are the winner's flags, gated by aligned, by !rst, and by grant.
- No grant: both enables are 0, and the other mem outputs hold the port-0 values (don't-care).

**Response tracking**
- Registered `resp_v`, `resp_owner`, `resp_load`, `resp_err` are set on every grant.
- In the response cycle the owner sees rvalid=1 and err=`resp_err`.
- rdata = `mem_rdata` if `resp_load & !resp_err`, else 0.
- The non-owner port sees rvalid=0, err=0, rdata=0.

**Stores**
- A store still produces an rvalid pulse (write acknowledge) with rdata=0.

## Timing
- Grant is combinational in cycle N, and the memory enable is asserted in cycle N.
- The response is in cycle N+1, so load-to-use latency is 1 cycle.
- Throughput is one access per cycle. Back-to-back grants are allowed, and responses pipeline one behind grants.
- Fairness: under continuous contention the grants alternate 0,1,0,1… A port waits at most 1 cycle.
- A requester may change its request in the cycle after its grant (the next access). Requests are never cancelled once raised.
- Reset values:
  - `prio`=0, `resp_v`=0.
  - All gnt/rvalid/err = 0, all rdata = 0.
  - `mem_is_load`/`mem_is_store` = 0.
- Reset asserted mid-access: memory enables drop immediately (asynchronously) and the pending response is discarded. After release, the first contested grant goes to port 0.
- Same-cycle conflict on one address: only one port is granted, so no simultaneous memory access exists. A store at cycle N followed by a load to the same address at N+1 returns the stored data.

## Test plan
- **Single load:** port 0 LW addr 0x10, memory word 0xDEADBEEF → p0_gnt=1 in cycle 0; mem_is_load=1, mem_addr=0x10; in cycle 1 p0_rvalid=1, p0_err=0, p0_rdata=0xDEADBEEF, p1_rvalid=0.
- **Contention:** both ports issue LW every cycle for 6 cycles after reset → grant sequence 0,1,0,1,0,1; each rvalid arrives 1 cycle after its grant, with correct per-port data.
- **Misalignment:** port 1 SH addr 0x23 → p1_gnt=1, mem_is_store=0; next cycle p1_rvalid=1, p1_err=1, p1_rdata=0. Port 1 LW addr 0x22 → same rejection.
- **Store then load:** port 1 SB addr 0x41 data 0xA5, then port 0 LBU addr 0x41 → p0_rdata=0x000000A5; port 1 receives a write acknowledge with rdata=0.
- **Reset mid-access:** assert rst in the cycle a LW is granted → mem_is_load drops at once; no rvalid after release; the next contested pair grants port 0 first.
- **Uncontested grants keep priority:** port 1 issues 3 solo requests, then both ports request → port 0 is granted (prio still 0).
